// File: rtl/sc_reduce_mod_l.sv
// Reduces a 512-bit little-endian digest modulo the Ed25519 group order L using
// MSB-first restoring reduction, BITS_PER_CYCLE digest bits per RUN cycle.
module sc_reduce_mod_l #(
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned IN_W           = 512
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_reduce,
  input  logic [IN_W-1:0] hash_in,
  output logic            busy,
  output logic            end_reduce,
  output logic [255:0]    scalar_out
);

  localparam int unsigned N     = IN_W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [255:0]     L_FULL   =
    256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;
  localparam logic [253:0]     L_MOD    = L_FULL[253:0];
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   shreg_q, shreg_d;
  logic [252:0]      rem_q,   rem_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [255:0]      scalar_q, scalar_d;

  logic [IN_W-1:0]   sh_step;
  logic [252:0]      rem_step;
  logic [253:0]      trial;

  // rem stays below L < 2^253, so {rem,bit} < 2L and one conditional subtract suffices.
  always_comb begin
    sh_step  = shreg_q;
    rem_step = rem_q;
    trial    = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      trial = {rem_step, sh_step[IN_W-1]};
      if (trial >= L_MOD) begin
        trial = trial - L_MOD;
      end
      rem_step = trial[252:0];
      sh_step  = sh_step << 1;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    scalar_d = scalar_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_reduce) begin
          state_d = S_RUN;
          shreg_d = hash_in;
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        shreg_d = sh_step;
        rem_d   = rem_step;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          scalar_d = {3'b000, rem_step};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      scalar_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      scalar_q <= scalar_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign end_reduce = (state_q == S_DONE);
  assign scalar_out = scalar_q;

endmodule
